// File: rtl/mux2_rr_feeder.sv
`default_nettype none
// ============================================================================
// Module      : mux2_rr_feeder
// Description : Upstream feeder for a 2:1 mux of WIDTH-bit operands.
//               Two independent valid/ready channels (A, B) are each buffered
//               in a one-word holding register. A round-robin arbiter picks a
//               channel whenever the output slot is free or being drained,
//               and presents registered operands a, b and select s
//               (0 = A, 1 = B) with a y_valid/y_ready handshake.
//
//               Ports:
//                 clk, rst_n        clock, asynchronous active-low reset
//                 a_in/a_valid/a_ready  channel A input handshake
//                 b_in/b_valid/b_ready  channel B input handshake
//                 a, b, s           registered mux operands and select
//                 y_valid, y_ready  output handshake qualifying mux y
// Revision    : 1.0 - initial release
// ============================================================================
module mux2_rr_feeder #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a_in,
    input  logic             a_valid,
    output logic             a_ready,
    input  logic [WIDTH-1:0] b_in,
    input  logic             b_valid,
    output logic             b_ready,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic             s,
    output logic             y_valid,
    input  logic             y_ready
);

    // Holding registers, one word per channel
    logic [WIDTH-1:0] r_a_hold;
    logic [WIDTH-1:0] r_b_hold;
    logic             r_a_full;
    logic             r_b_full;

    // Output slot
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_s;
    logic             r_y_valid;

    // Channel granted most recently (0 = A, 1 = B); reset to B so A wins
    // the first contention.
    logic             r_last_grant;

    logic             w_load;
    logic             w_grant_a;
    logic             w_grant_b;
    logic             w_accept_a;
    logic             w_accept_b;

    // The output slot can take a new word when empty or drained this cycle.
    assign w_load = !r_y_valid || y_ready;

    always_comb begin
        w_grant_a = 1'b0;
        w_grant_b = 1'b0;
        if (w_load) begin
            if (r_a_full && r_b_full) begin
                w_grant_a = r_last_grant;
                w_grant_b = !r_last_grant;
            end else begin
                w_grant_a = r_a_full;
                w_grant_b = r_b_full;
            end
        end
    end

    // A channel whose word is leaving this cycle can be refilled in the same
    // cycle, giving one word per cycle per channel when uncontended. This
    // creates a combinational path from y_ready to the ready outputs.
    assign a_ready    = !r_a_full || w_grant_a;
    assign b_ready    = !r_b_full || w_grant_b;
    assign w_accept_a = a_valid && a_ready;
    assign w_accept_b = b_valid && b_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_hold <= '0;
            r_b_hold <= '0;
            r_a_full <= 1'b0;
            r_b_full <= 1'b0;
        end else begin
            if (w_accept_a) begin
                r_a_hold <= a_in;
                r_a_full <= 1'b1;
            end else if (w_grant_a) begin
                r_a_full <= 1'b0;
            end
            if (w_accept_b) begin
                r_b_hold <= b_in;
                r_b_full <= 1'b1;
            end else if (w_grant_b) begin
                r_b_full <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a          <= '0;
            r_b          <= '0;
            r_s          <= 1'b0;
            r_y_valid    <= 1'b0;
            r_last_grant <= 1'b1;
        end else if (w_load) begin
            if (w_grant_a || w_grant_b) begin
                // Both operands are copied; the non-selected one mirrors its
                // current holding register.
                r_a          <= r_a_hold;
                r_b          <= r_b_hold;
                r_s          <= w_grant_b;
                r_y_valid    <= 1'b1;
                r_last_grant <= w_grant_b;
            end else begin
                r_y_valid <= 1'b0;
            end
        end
    end

    assign a       = r_a;
    assign b       = r_b;
    assign s       = r_s;
    assign y_valid = r_y_valid;

endmodule
`default_nettype wire

// File: tb/tb_mux2_rr_feeder.sv
`default_nettype none
// ============================================================================
// Module      : tb_mux2_rr_feeder
// Description : Self-checking bench for mux2_rr_feeder. A queue-based model
//               of the two channel buffers and the output slot predicts
//               ready, a, b, s and y_valid every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mux2_rr_feeder;

    localparam int WIDTH = 4;

    logic             clk;
    logic             rst_n;
    logic [WIDTH-1:0] a_in;
    logic             a_valid;
    logic             a_ready;
    logic [WIDTH-1:0] b_in;
    logic             b_valid;
    logic             b_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             s;
    logic             y_valid;
    logic             y_ready;

    int total;
    int bad;

    mux2_rr_feeder #(.WIDTH(WIDTH)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .a_in    (a_in),
        .a_valid (a_valid),
        .a_ready (a_ready),
        .b_in    (b_in),
        .b_valid (b_valid),
        .b_ready (b_ready),
        .a       (a),
        .b       (b),
        .s       (s),
        .y_valid (y_valid),
        .y_ready (y_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [WIDTH-1:0] qa[$];      // words waiting in channel A (max one)
    logic [WIDTH-1:0] qb[$];
    logic [WIDTH-1:0] last_a_word; // most recently accepted word per channel
    logic [WIDTH-1:0] last_b_word;
    logic             m_yv;
    logic [WIDTH-1:0] m_a;
    logic [WIDTH-1:0] m_b;
    logic             m_s;
    int               m_last;      // 0 = A granted last, 1 = B granted last

    task automatic model_reset();
        qa.delete();
        qb.delete();
        last_a_word = '0;
        last_b_word = '0;
        m_yv   = 1'b0;
        m_a    = '0;
        m_b    = '0;
        m_s    = 1'b0;
        m_last = 1;
    endtask

    // Which channel goes out this cycle: -1 none, 0 A, 1 B.
    function automatic int pick(input logic yr);
        if (m_yv && !yr)                     return -1;
        if (qa.size() > 0 && qb.size() > 0)  return 1 - m_last;
        if (qa.size() > 0)                   return 0;
        if (qb.size() > 0)                   return 1;
        return -1;
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_outputs(input logic exp_ar, input logic exp_br);
        chk("a_ready", {7'd0, a_ready}, {7'd0, exp_ar});
        chk("b_ready", {7'd0, b_ready}, {7'd0, exp_br});
        chk("y_valid", {7'd0, y_valid}, {7'd0, m_yv});
        chk("s",       {7'd0, s},       {7'd0, m_s});
        chk("a",       {4'd0, a},       {4'd0, m_a});
        chk("b",       {4'd0, b},       {4'd0, m_b});
    endtask

    // One clock cycle: called just after a rising edge. Drives inputs, checks
    // at the falling edge, then advances the model at the rising edge.
    task automatic cycle(input logic av, input logic [WIDTH-1:0] ad,
                         input logic bv, input logic [WIDTH-1:0] bd,
                         input logic yr);
        int  g;
        logic ar, br;
        a_valid = av; a_in = ad;
        b_valid = bv; b_in = bd;
        y_ready = yr;
        @(negedge clk);
        g  = pick(yr);
        ar = (qa.size() == 0) || (g == 0);
        br = (qb.size() == 0) || (g == 1);
        check_outputs(ar, br);
        @(posedge clk);
        if (g >= 0) begin
            m_a    = last_a_word;
            m_b    = last_b_word;
            m_s    = (g == 1);
            m_yv   = 1'b1;
            m_last = g;
            if (g == 0) void'(qa.pop_front());
            else        void'(qb.pop_front());
        end else if (!m_yv || yr) begin
            m_yv = 1'b0;
        end
        if (av && ar) begin qa.push_back(ad); last_a_word = ad; end
        if (bv && br) begin qb.push_back(bd); last_b_word = bd; end
        #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        model_reset();

        // Reset with both channels presenting data
        rst_n   = 1'b0;
        a_valid = 1'b1; a_in = 4'd3;
        b_valid = 1'b1; b_in = 4'd9;
        y_ready = 1'b1;
        #3;
        check_outputs(1'b1, 1'b1);
        @(negedge clk);
        check_outputs(1'b1, 1'b1);
        a_valid = 1'b0;
        b_valid = 1'b0;
        rst_n   = 1'b1;
        @(posedge clk); #1;

        // Idle after release: nothing appears
        cycle(0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 1);

        // A-only stream 3, 5, 9
        cycle(1, 3, 0, 0, 1);
        cycle(1, 5, 0, 0, 1);
        cycle(1, 9, 0, 0, 1);
        cycle(0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 1);

        // Continuous contention: A = 1,2,3 ; B = 10,11,12
        for (int i = 0; i < 3; i++) begin
            cycle(1, 4'(1 + i), 1, 4'(10 + i), 1);
            cycle(0, 0, 0, 0, 1);
        end
        for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0, 1);

        // Backpressure: 7 stalls in the slot, 6 fills the hold, then refused
        cycle(1, 7, 0, 0, 0);
        for (int i = 0; i < 4; i++) cycle(1, 4'(6 + i), 0, 0, 0);
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 1);

        // B alone, then A while B held full under stall
        cycle(0, 0, 1, 12, 0);
        cycle(0, 0, 0, 0, 0);
        cycle(1, 4, 1, 13, 0);
        cycle(0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) cycle(0, 0, 0, 0, 1);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom_range(0, 1)), 4'($urandom),
                  1'($urandom_range(0, 1)), 4'($urandom),
                  ($urandom_range(0, 3) != 0));
        end

        // Mid-operation reset: both holds full and slot valid
        cycle(1, 5, 1, 6, 0);
        cycle(1, 7, 1, 8, 0);
        cycle(1, 9, 1, 10, 0);
        chk("full_before_rst_yv", {7'd0, y_valid}, 8'd1);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs(1'b1, 1'b1);
        a_valid = 1'b0;
        b_valid = 1'b0;
        y_ready = 1'b1;
        @(negedge clk);
        check_outputs(1'b1, 1'b1);
        rst_n = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0, 1);
        cycle(0, 0, 1, 2, 1);
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
